pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
- Two-stage pipelined WIDTH-bit add/subtract unit built from 8-bit carry-lookahead blocks.
- Stage 1 forms per-bit generate/propagate and per-block group generate/propagate and registers them. Stage 2 resolves block carry-ins, intra-block carries, sum and flags into an output register.
- Sits between the execute-stage operand muxes and the writeback/bypass path.
- Uses a valid/ready handshake on both sides so the pipeline can be stalled without losing data.

Parameters:
- WIDTH, 32, operand width; must be a multiple of 8.
- TAG_W, 5, width of the sideband tag (destination register index) carried alongside each operation.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  pipeline accepts operands this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  1 = A-B (B inverted, carry-in 1); 0 = A+B (carry-in 0).
- in_tag  input  TAG_W  sideband, returned unchanged with the result.
- out_valid  output  1  result register holds a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- out_sum  output  WIDTH  A+B or A-B, modulo 2^WIDTH.
- out_cout  output  1  carry out of the MSB (for sub: 1 = no borrow).
- out_ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- out_zero  output  1  out_sum == 0.
- out_lt  output  1  signed less-than = out_sum[WIDTH-1] XOR out_ovf; meaningful for sub, computed for both.
- out_tag  output  TAG_W  tag of the operation in the result register.

Behaviour:
- Reset (clock edge with reset=1): s1_valid=0, out_valid=0; out_sum, out_cout, out_ovf, out_zero, out_lt, out_tag all 0. Datapath registers are also cleared.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Stage 1, combinational from inputs:
  - bb = in_sub ? ~in_b : in_b; g = in_a & bb; p = in_a ^ bb; cin = in_sub.
  - For each 8-bit block k: G_k = g7 | p7g6 | ... | p7..p1g0; P_k = AND of p7..p0.
- Stage 1 register: holds p, g, G[WIDTH/8-1:0], P[WIDTH/8-1:0], cin, tag, s1_valid.
- Stage 2, combinational from the stage-1 register:
  - Block carry-ins: C_0 = cin; C_{k+1} = G_k | P_k & C_k, computed in lookahead (flattened) form, not rippled.
  - Intra-block carries use 8-bit lookahead from C_k.
  - sum = p ^ carries. cout = C_{WIDTH/8}. ovf = carry into bit WIDTH-1 XOR cout.
- Output register loads sum, cout, ovf, zero, lt, tag on advance.
- Flow control:
  - s2_adv = s1_valid & (~out_valid | out_ready).
  - in_ready = ~s1_valid | s2_adv. This is combinational through out_ready; no skid buffer.
  - Stage 1 loads on input transfer.
  - s1_valid next = input transfer ? 1 : (s2_adv ? 0 : s1_valid).
  - out_valid next = s2_adv ? 1 : (out_ready ? 0 : out_valid).
- Latency and throughput: 2 cycles from accept to out_valid; one result per cycle with out_ready held 1.
- Stall: while out_valid & ~out_ready, the output register and all outputs hold stable. Stage 1 holds if full. in_ready=0 only when both stages are full and out_ready=0.
- Simultaneous accept and drain in the same cycle is legal in both stages; no bubble is inserted.
- Wrap-around: sum is modulo 2^WIDTH; cout/ovf report overflow; no saturation.
- Reset mid-operation: all in-flight operations are discarded; no output transfer occurs for them. in_ready=1 in the first cycle after reset.
- in_a, in_b, in_sub, in_tag are ignored when in_valid=0.

Test Plan:
- Add, no stall: A=0x7FFFFFFF, B=1, sub=0, tag=3, out_ready=1 -> 2 cycles later out_valid=1, sum=0x80000000, ovf=1, cout=0, zero=0, tag=3.
- Subtract, equal operands: A=B=0x12345678, sub=1 -> sum=0, zero=1, cout=1, ovf=0, lt=0. Then A=5, B=7, sub=1 -> sum=0xFFFFFFFE, lt=1, cout=0.
- Full carry chain: A=0xFFFFFFFF, B=1, sub=0 -> sum=0, cout=1, zero=1, ovf=0, which exercises every block carry-in.
- Back-to-back with backpressure: issue 4 ops (tags 0..3) on consecutive cycles; hold out_ready=0 for 3 cycles starting when tag 0 appears -> in_ready drops once both stages are full, outputs stay stable, tags emerge in order 0,1,2,3 with none lost or duplicated.
- Reset mid-flight: accept 2 ops, assert reset for 1 cycle -> out_valid=0 and all outputs 0 after the edge, in_ready=1, no stale result appears afterwards.
- Random: 10k random A/B/sub with random out_ready -> every result matches the reference model A±B mod 2^32 and the flags, in issue order.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined add/subtract unit built from 8-bit carry-lookahead blocks,
// with valid/ready flow control on both sides.

module cla8_gp (
    input  logic [7:0] p,
    input  logic [7:0] g,
    output logic       gg,
    output logic       pp
);
    logic term;

    always_comb begin
        gg   = 1'b0;
        term = 1'b0;
        for (int j = 0; j < 8; j++) begin
            term = g[j];
            for (int m = j + 1; m < 8; m++) term = term & p[m];
            gg = gg | term;
        end
        pp = &p;
    end
endmodule

// Carry into each bit of one block, sum-of-products form from the block carry-in.
module cla8_sum (
    input  logic [6:0] p,
    input  logic [6:0] g,
    input  logic       cin,
    output logic [7:0] c
);
    logic acc;
    logic term;

    always_comb begin
        c    = '0;
        acc  = 1'b0;
        term = 1'b0;
        for (int i = 0; i < 8; i++) begin
            acc = cin;
            for (int j = 0; j < i; j++) acc = acc & p[j];
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) term = term & p[m];
                acc = acc | term;
            end
            c[i] = acc;
        end
    end
endmodule

module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_lt,
    output logic [TAG_W-1:0] out_tag
);
    localparam int NB = WIDTH / 8;

    logic             in_xfer, s2_adv;
    logic [WIDTH-1:0] bb, new_g, new_p;
    logic [NB-1:0]    new_gg, new_pp;

    logic [WIDTH-1:0] g_d, g_q, p_d, p_q;
    logic [NB-1:0]    gg_d, gg_q, pp_d, pp_q;
    logic             cin_d, cin_q, s1_valid_d, s1_valid_q;
    logic [TAG_W-1:0] s1_tag_d, s1_tag_q;

    logic [NB:0]      blk_c;
    logic [WIDTH-1:0] carry, sum2;
    logic             c_acc, term, cout2, ovf2;

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q, ovf_d, ovf_q, zero_d, zero_q, lt_d, lt_q;
    logic             out_valid_d, out_valid_q;
    logic [TAG_W-1:0] tag_d, tag_q;

    assign s2_adv   = s1_valid_q & (~out_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | s2_adv;
    assign in_xfer  = in_valid & in_ready;

    assign bb    = in_sub ? ~in_b : in_b;
    assign new_g = in_a & bb;
    assign new_p = in_a ^ bb;

    for (genvar k = 0; k < NB; k++) begin : g_blk
        cla8_gp u_gp (
            .p  (new_p[8*k +: 8]),
            .g  (new_g[8*k +: 8]),
            .gg (new_gg[k]),
            .pp (new_pp[k])
        );
        cla8_sum u_sum (
            .p   (p_q[8*k +: 7]),
            .g   (g_q[8*k +: 7]),
            .cin (blk_c[k]),
            .c   (carry[8*k +: 8])
        );
    end

    always_comb begin
        g_d        = in_xfer ? new_g  : g_q;
        p_d        = in_xfer ? new_p  : p_q;
        gg_d       = in_xfer ? new_gg : gg_q;
        pp_d       = in_xfer ? new_pp : pp_q;
        cin_d      = in_xfer ? in_sub : cin_q;
        s1_tag_d   = in_xfer ? in_tag : s1_tag_q;
        s1_valid_d = in_xfer ? 1'b1 : (s2_adv ? 1'b0 : s1_valid_q);
    end

    // Block carry-ins flattened: C_{k+1} = OR_j (G_j & P_{j+1..k}) | (P_{0..k} & cin).
    always_comb begin
        blk_c    = '0;
        blk_c[0] = cin_q;
        c_acc    = 1'b0;
        term     = 1'b0;
        for (int k = 0; k < NB; k++) begin
            c_acc = cin_q;
            for (int j = 0; j <= k; j++) c_acc = c_acc & pp_q[j];
            for (int j = 0; j <= k; j++) begin
                term = gg_q[j];
                for (int m = j + 1; m <= k; m++) term = term & pp_q[m];
                c_acc = c_acc | term;
            end
            blk_c[k+1] = c_acc;
        end
    end

    assign sum2  = p_q ^ carry;
    assign cout2 = blk_c[NB];
    assign ovf2  = carry[WIDTH-1] ^ cout2;

    always_comb begin
        sum_d       = s2_adv ? sum2                    : sum_q;
        cout_d      = s2_adv ? cout2                   : cout_q;
        ovf_d       = s2_adv ? ovf2                    : ovf_q;
        zero_d      = s2_adv ? (sum2 == '0)            : zero_q;
        lt_d        = s2_adv ? (sum2[WIDTH-1] ^ ovf2)  : lt_q;
        tag_d       = s2_adv ? s1_tag_q                : tag_q;
        out_valid_d = s2_adv ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            g_q         <= '0;
            p_q         <= '0;
            gg_q        <= '0;
            pp_q        <= '0;
            cin_q       <= 1'b0;
            s1_tag_q    <= '0;
            s1_valid_q  <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            lt_q        <= 1'b0;
            tag_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            g_q         <= g_d;
            p_q         <= p_d;
            gg_q        <= gg_d;
            pp_q        <= pp_d;
            cin_q       <= cin_d;
            s1_tag_q    <= s1_tag_d;
            s1_valid_q  <= s1_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            lt_q        <= lt_d;
            tag_q       <= tag_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;
    assign out_lt    = lt_q;
    assign out_tag   = tag_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: driver pushes expected results,
// a negedge monitor compares whatever the DUT presents.

module tb_pipelined_cla_adder;
    logic        clock = 1'b0;
    logic        reset, in_valid, in_ready, in_sub, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_sum;
    logic [4:0]  in_tag, out_tag;
    logic        out_cout, out_ovf, out_zero, out_lt;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout, ovf, zero, lt;
        logic [4:0]  tag;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    bit   saw_stall;

    pipelined_cla_adder #(.WIDTH(32), .TAG_W(5)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .out_zero(out_zero), .out_lt(out_lt), .out_tag(out_tag)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Reference: true signed/unsigned arithmetic, not carry equations.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic [4:0] tag);
        exp_t        e;
        logic [32:0] r;
        longint      sa, sb, ts;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            e.sum  = a - b;
            e.cout = (a >= b);
            ts     = sa - sb;
        end else begin
            r      = {1'b0, a} + {1'b0, b};
            e.sum  = r[31:0];
            e.cout = r[32];
            ts     = sa + sb;
        end
        e.ovf  = (ts > 64'sd2147483647) || (ts < -64'sd2147483648);
        e.zero = (e.sum == 32'd0);
        e.lt   = (ts < 0);
        e.tag  = tag;
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o,
                                input logic z, input logic l, input logic [4:0] t);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o; e.zero = z; e.lt = l; e.tag = t;
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called and returns at posedge+1; holds the op until accepted.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [4:0] tag, input exp_t e);
        int n = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_tag = tag;
        forever begin
            @(negedge clock);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                total++; bad++;
                $display("FAIL accept_timeout: tag %0d not accepted within 100 cycles", tag);
                @(posedge clock); #1 in_valid = 1'b0;
                return;
            end
        end
        @(posedge clock);
        q.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, !(q.size() == 2 && !out_ready)});
            if (out_valid) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_result: got sum %h tag %0d want none", out_sum, out_tag);
                end else begin
                    mon_e = q[0];
                    chk("result", {23'd0, out_sum, out_cout, out_ovf, out_zero, out_lt, out_tag},
                        {23'd0, mon_e});
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   ops, cyc;
        bit   acc;
        exp_t pend;
        logic [31:0] ra, rb;
        logic        rs;
        logic [4:0]  rt;

        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
        in_tag = '0; out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_outputs", {23'd0, out_sum, out_cout, out_ovf, out_zero, out_lt, out_tag}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clock); #1;

        // Directed vectors with hand-derived results
        out_ready = 1'b1;
        issue(32'h7FFF_FFFF, 32'h1, 1'b0, 5'd3, mk(32'h8000_0000, 0, 1, 0, 0, 5'd3));
        @(negedge clock);
        chk("lat_stage1", {63'd0, out_valid}, 64'd0);
        @(negedge clock);
        chk("lat_stage2", {63'd0, out_valid}, 64'd1);
        @(posedge clock); #1;
        issue(32'h1234_5678, 32'h1234_5678, 1'b1, 5'd4, mk(32'h0, 1, 0, 1, 0, 5'd4));
        issue(32'd5, 32'd7, 1'b1, 5'd5, mk(32'hFFFF_FFFE, 0, 0, 0, 1, 5'd5));
        issue(32'hFFFF_FFFF, 32'h1, 1'b0, 5'd6, mk(32'h0, 1, 0, 1, 0, 5'd6));
        issue(32'h8000_0000, 32'h1, 1'b1, 5'd7, mk(32'h7FFF_FFFF, 1, 1, 0, 1, 5'd7));
        idle(4);
        chk("directed_drain", q.size(), 64'd0);

        // Back-to-back with a 3-cycle output stall
        saw_stall = 1'b0;
        fork
            begin
                for (int t = 0; t < 4; t++) begin
                    ra = $urandom; rb = $urandom; rs = t[0];
                    issue(ra, rb, rs, t[4:0], model(ra, rb, rs, t[4:0]));
                end
            end
            begin
                int n = 0;
                while (!out_valid && n < 50) begin
                    @(negedge clock);
                    n++;
                end
                @(posedge clock); #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clock);
                    if (!in_ready) saw_stall = 1'b1;
                end
                @(posedge clock); #1 out_ready = 1'b1;
            end
        join
        chk("stall_in_ready_dropped", {63'd0, saw_stall}, 64'd1);
        idle(6);
        chk("stall_drain", q.size(), 64'd0);

        // Reset with two ops in flight
        out_ready = 1'b0;
        issue(32'd10, 32'd20, 1'b0, 5'd9, model(32'd10, 32'd20, 1'b0, 5'd9));
        issue(32'd30, 32'd40, 1'b1, 5'd10, model(32'd30, 32'd40, 1'b1, 5'd10));
        reset = 1'b1;
        @(posedge clock);
        q.delete();
        #1 reset = 1'b0;
        @(negedge clock);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_outputs", {23'd0, out_sum, out_cout, out_ovf, out_zero, out_lt, out_tag}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clock); #1;
        out_ready = 1'b1;
        idle(6);

        // Random ops and random backpressure
        ops = 0;
        for (cyc = 0; cyc < 60000 && ops < 10000; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 4) != 0) begin
                ra = pick(); rb = pick(); rs = $urandom_range(0, 1); rt = 5'($urandom);
                in_a = ra; in_b = rb; in_sub = rs; in_tag = rt;
                pend = model(ra, rb, rs, rt);
                in_valid = 1'b1;
            end
            @(negedge clock);
            acc = in_valid && in_ready;
            @(posedge clock);
            if (acc) begin
                q.push_back(pend);
                ops++;
            end
            #1;
            if (acc) in_valid = 1'b0;
        end
        chk("random_ops_issued", ops, 64'd10000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(10);
        chk("random_drain", q.size(), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
